naneye_rx_top: RTL and testbench

//  Receive-side top for a NanEye-style image sensor link. Oversamples the Manchester RX_DATA line
//  on SCLOCK (400 MHz nominal, ~62.6 Mb/s line, ~6.4 samples/bit) and decodes it into bits.

---
 rtl/naneye_rx_top.sv | 245 ++++++++++++++++++++++++
 tb/tb_naneye_rx_top.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/naneye_rx_top.sv
// rtl/naneye_rx_top.sv - NanEye-style Manchester link receiver with pixel framing
// Purpose: oversample RX_DATA on SCLOCK, decode Manchester bits, frame 12-bit words
//   (start '1', D_WIDTH data MSB-first, stop '0') into a parallel pixel bus, report
//   code/stop/break errors and expose the sensor configuration register.
// Ports: SCLOCK/RESET sole clock and async active-low reset; SYS_CLOCK unused;
//   RX_DATA Manchester input; ERROR_OUT code-error pulse; ERROR_OUT2 stop-bit pulse;
//   BREAK_N [0] line ok / [1] last frame complete; TX_OE_N/TX_DAT/TX_CLK config
//   transmitter; PAR_RAW/PCLK/H_SYNC/V_SYNC pixel bus; I2C_SDA/I2C_SCL reserved high-Z;
//   MCLK_SPEED/IDLE_MODE/MCLK_MODE/ROWS_DELAY configuration register fields.
// Option macro: CFG_TX_EN enables serialising the config register on each new sync.
module naneye_rx_top #(
  parameter int D_WIDTH = 10,
  parameter int COLS = 250,
  parameter int ROWS = 250,
  parameter int HALF_MAX = 4,
  parameter int LONG_MAX = 8,
  parameter int SYNC_BITS = 16,
  parameter int IDLE_MAX = 64,
  parameter int PCLK_HI = 4,
  parameter int TX_DIV = 8,
  parameter logic [8:0] CFG_DEF = 9'h000
) (
  input  logic               SCLOCK,
  input  logic               RESET,
  input  logic               SYS_CLOCK,
  input  logic               RX_DATA,
  output logic               ERROR_OUT,
  output logic               ERROR_OUT2,
  output logic [1:0]         BREAK_N,
  output logic               TX_OE_N,
  output logic               TX_DAT,
  output logic               TX_CLK,
  output logic [D_WIDTH-1:0] PAR_RAW,
  output logic               PCLK,
  output logic               H_SYNC,
  output logic               V_SYNC,
  inout  wire                I2C_SDA,
  inout  wire                I2C_SCL,
  output logic               MCLK_SPEED,
  output logic               IDLE_MODE,
  output logic [1:0]         MCLK_MODE,
  output logic [4:0]         ROWS_DELAY
);
  localparam int CW  = $clog2(IDLE_MAX + 2);
  localparam int ZW  = $clog2(SYNC_BITS + 1);
  localparam int BW  = $clog2(D_WIDTH + 1);
  localparam int CLW = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int PW  = $clog2(PCLK_HI + 1);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic sys_clock_unused;
  assign sys_clock_unused = SYS_CLOCK;
  assign I2C_SDA = 1'bz;
  assign I2C_SCL = 1'bz;

  // ---------------- Manchester decoder ----------------
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;            // samples since the last edge, saturating
  logic          locked, mid;    // mid: last accepted edge was a mid-bit transition
  logic          bit_v, bit_d, code_err, brk, line_ok;

  wire edge_det = rx_s2 ^ rx_d;
  wire is_short = (cnt <= CW'(HALF_MAX));
  wire is_long  = (cnt > CW'(HALF_MAX)) && (cnt <= CW'(LONG_MAX));

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      {rx_s1, rx_s2, rx_d} <= 3'b000;
      cnt <= '0; locked <= 1'b0; mid <= 1'b0;
      bit_v <= 1'b0; bit_d <= 1'b0; code_err <= 1'b0; brk <= 1'b0; line_ok <= 1'b1;
    end else begin
      rx_s1 <= RX_DATA; rx_s2 <= rx_s1; rx_d <= rx_s2;
      bit_v <= 1'b0; code_err <= 1'b0; brk <= 1'b0;
      if (edge_det) begin
        cnt <= CW'(1);
        if (!locked) begin
          // A full-bit interval can only end on a mid-bit transition.
          if (is_long) begin
            locked <= 1'b1; mid <= 1'b1; line_ok <= 1'b1;
            bit_v <= 1'b1; bit_d <= rx_s2;
          end
        end else if (is_short) begin
          mid <= !mid;
          if (!mid) begin bit_v <= 1'b1; bit_d <= rx_s2; end
        end else if (is_long && mid) begin
          bit_v <= 1'b1; bit_d <= rx_s2;
        end else begin
          // Long interval from a boundary, or no valid interval at all: lose lock.
          code_err <= 1'b1; locked <= 1'b0;
        end
      end else begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (cnt == CW'(IDLE_MAX)) begin
          brk <= 1'b1; locked <= 1'b0; line_ok <= 1'b0;
        end
      end
    end
  end

  assign ERROR_OUT = code_err;

  // ---------------- Word framer ----------------
  logic [1:0]         state;
  logic [BW-1:0]      bcnt;
  logic [D_WIDTH-1:0] shreg, word_d;
  logic [ZW-1:0]      zrun;
  logic               in_sync, in_sync_d, word_v, word_first;
  logic               frame_active, frame_ok;

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= S_HUNT; bcnt <= '0; shreg <= '0; word_d <= '0; zrun <= '0;
      in_sync <= 1'b0; word_v <= 1'b0; word_first <= 1'b0; ERROR_OUT2 <= 1'b0;
    end else begin
      word_v <= 1'b0; ERROR_OUT2 <= 1'b0;
      if (code_err || brk) begin
        state <= S_HUNT; zrun <= '0;
        if (brk) in_sync <= 1'b0;
      end else if (bit_v) begin
        case (state)
          S_HUNT: begin
            if (bit_d) begin
              state <= S_DATA; bcnt <= '0; zrun <= '0;
            end else if (zrun != ZW'(SYNC_BITS)) begin
              zrun <= zrun + 1'b1;
              if (zrun == ZW'(SYNC_BITS - 1)) in_sync <= 1'b1;
            end
          end
          S_DATA: begin
            shreg <= {shreg[D_WIDTH-2:0], bit_d};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == BW'(D_WIDTH - 1)) state <= S_STOP;
          end
          default: begin
            state <= S_HUNT;
            if (bit_d) begin
              ERROR_OUT2 <= 1'b1;
            end else if (in_sync || frame_active) begin
              word_v <= 1'b1; word_d <= shreg; word_first <= in_sync;
              in_sync <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- Pixel bus ----------------
  logic [CLW-1:0] col;
  logic [RW-1:0]  row;
  logic [PW-1:0]  pcnt;
  logic           pclk_pend;

  wire pclk_fall = PCLK && (pcnt == '0) && !pclk_pend;
  wire abort     = frame_active && (brk || (in_sync && !in_sync_d));

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      PAR_RAW <= '0; PCLK <= 1'b0; H_SYNC <= 1'b0; V_SYNC <= 1'b0;
      col <= '0; row <= '0; pcnt <= '0; pclk_pend <= 1'b0;
      frame_active <= 1'b0; frame_ok <= 1'b1; in_sync_d <= 1'b0;
    end else begin
      in_sync_d <= in_sync;
      pclk_pend <= 1'b0;
      if (pclk_pend) begin
        PCLK <= 1'b1; pcnt <= PW'(PCLK_HI - 1);
      end else if (PCLK) begin
        if (pcnt == '0) PCLK <= 1'b0;
        else pcnt <= pcnt - 1'b1;
      end
      if (abort) begin
        H_SYNC <= 1'b0; V_SYNC <= 1'b0; frame_ok <= 1'b0;
        frame_active <= 1'b0; col <= '0; row <= '0;
      end else if (word_v) begin
        PAR_RAW <= word_d; H_SYNC <= 1'b1; pclk_pend <= 1'b1;
        if (word_first) begin
          V_SYNC <= 1'b1; frame_active <= 1'b1; col <= '0; row <= '0;
        end
      end else if (pclk_fall && frame_active) begin
        // Row/frame bookkeeping happens as the word's strobe ends.
        if (col == CLW'(COLS - 1)) begin
          col <= '0; H_SYNC <= 1'b0;
          if (row == RW'(ROWS - 1)) begin
            row <= '0; V_SYNC <= 1'b0; frame_active <= 1'b0; frame_ok <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign BREAK_N = {frame_ok, line_ok};

  // ---------------- Configuration register ----------------
  logic [8:0] cfg;
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) cfg <= CFG_DEF;
  end

  assign MCLK_SPEED = cfg[0];
  assign IDLE_MODE  = cfg[1];
  assign MCLK_MODE  = cfg[3:2];
  assign ROWS_DELAY = cfg[8:4];

`ifdef CFG_TX_EN
  localparam int DW = $clog2(TX_DIV);
  logic [15:0]   tx_sh;
  logic [3:0]    tx_bits;
  logic [DW-1:0] tx_ph;
  logic          tx_busy;

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      tx_sh <= '0; tx_bits <= '0; tx_ph <= '0; tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (in_sync && !in_sync_d) begin
        tx_busy <= 1'b1; tx_sh <= {cfg, 7'b0}; tx_bits <= '0; tx_ph <= '0;
      end
    end else if (tx_ph == DW'(TX_DIV - 1)) begin
      // TX_CLK falls here, so data advances on the falling edge.
      tx_ph <= '0; tx_sh <= {tx_sh[14:0], 1'b0};
      if (tx_bits == 4'd15) tx_busy <= 1'b0;
      else tx_bits <= tx_bits + 1'b1;
    end else begin
      tx_ph <= tx_ph + 1'b1;
    end
  end

  assign TX_OE_N = !tx_busy;
  assign TX_DAT  = tx_busy && tx_sh[15];
  assign TX_CLK  = tx_busy && (tx_ph >= DW'(TX_DIV / 2));
`else
  assign TX_OE_N = 1'b1;
  assign TX_DAT  = 1'b0;
  assign TX_CLK  = 1'b0;
`endif

endmodule

// File: tb/tb_naneye_rx_top.sv
// tb/tb_naneye_rx_top.sv - self-checking bench for naneye_rx_top
`timescale 1ns/1ps
module tb_naneye_rx_top;
  localparam int  COLS = 4;
  localparam int  ROWS = 2;
  localparam int  PCLK_HI = 4;
  localparam real HB = 7.987;

  logic SCLOCK = 1'b0, RESET = 1'b0, SYS_CLOCK = 1'b0, RX_DATA = 1'b0;
  logic ERROR_OUT, ERROR_OUT2, TX_OE_N, TX_DAT, TX_CLK, PCLK, H_SYNC, V_SYNC;
  logic MCLK_SPEED, IDLE_MODE;
  logic [1:0] BREAK_N, MCLK_MODE;
  logic [4:0] ROWS_DELAY;
  logic [9:0] PAR_RAW;
  wire I2C_SDA, I2C_SCL;

  naneye_rx_top #(.D_WIDTH(10), .COLS(COLS), .ROWS(ROWS), .PCLK_HI(PCLK_HI), .CFG_DEF(9'h1A5)) dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .SYS_CLOCK(SYS_CLOCK), .RX_DATA(RX_DATA),
    .ERROR_OUT(ERROR_OUT), .ERROR_OUT2(ERROR_OUT2), .BREAK_N(BREAK_N),
    .TX_OE_N(TX_OE_N), .TX_DAT(TX_DAT), .TX_CLK(TX_CLK), .PAR_RAW(PAR_RAW),
    .PCLK(PCLK), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .I2C_SDA(I2C_SDA), .I2C_SCL(I2C_SCL),
    .MCLK_SPEED(MCLK_SPEED), .IDLE_MODE(IDLE_MODE), .MCLK_MODE(MCLK_MODE), .ROWS_DELAY(ROWS_DELAY)
  );

  always #1.25 SCLOCK = ~SCLOCK;
  always #5 SYS_CLOCK = ~SYS_CLOCK;

  int n_cmp = 0, n_fail = 0;

  // Monitor, sampled on the inactive clock edge.
  int pclk_rises = 0, width_bad = 0, hv_bad = 0, h_rises = 0, v_falls = 0;
  int err_cnt = 0, err2_cnt = 0, tx_bad = 0, oe_run = 0, pcnt_hi = 0;
  logic [9:0] cap_q[$];
  int oe_runs[$];
  logic tx_bits_q[$];
  logic pclk_p = 1'b0, h_p = 1'b0, v_p = 1'b0, txclk_p = 1'b0;

  always @(negedge SCLOCK) begin
    if (PCLK && !pclk_p) begin
      pclk_rises <= pclk_rises + 1;
      cap_q.push_back(PAR_RAW);
      if (!(H_SYNC && V_SYNC)) hv_bad <= hv_bad + 1;
    end
    if (PCLK) pcnt_hi <= pcnt_hi + 1;
    else begin
      if (pclk_p && pcnt_hi != PCLK_HI) width_bad <= width_bad + 1;
      pcnt_hi <= 0;
    end
    if (H_SYNC && !h_p) h_rises <= h_rises + 1;
    if (!V_SYNC && v_p) v_falls <= v_falls + 1;
    if (ERROR_OUT) err_cnt <= err_cnt + 1;
    if (ERROR_OUT2) err2_cnt <= err2_cnt + 1;
    if (TX_OE_N === 1'b0) oe_run <= oe_run + 1;
    else if (oe_run != 0) begin oe_runs.push_back(oe_run); oe_run <= 0; end
    if (TX_CLK && !txclk_p) tx_bits_q.push_back(TX_DAT);
    if (TX_OE_N !== 1'b1 || TX_DAT !== 1'b0 || TX_CLK !== 1'b0) tx_bad <= tx_bad + 1;
    pclk_p <= PCLK; h_p <= H_SYNC; v_p <= V_SYNC; txclk_p <= TX_CLK;
  end

  // Word-level reference model of the link.
  logic [9:0] exp_q[$];
  int  m_zrun = 0, m_idx = 0, exp_h = 0, exp_vfall = 0, exp_err2 = 0;
  bit  m_sync = 0, m_active = 0;
  logic [1:0] exp_brk = 2'b11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RX_DATA = ~b; #(HB);
    RX_DATA = b;  #(HB);
  endtask

  task automatic send_zeros(input int n);
    int prev;
    for (int i = 0; i < n; i++) send_bit(1'b0);
    prev = m_zrun;
    m_zrun += n;
    if (prev < 16 && m_zrun >= 16) begin
      if (m_active) begin m_active = 0; exp_vfall++; exp_brk[1] = 1'b0; end
      m_sync = 1;
    end
  endtask

  task automatic send_word(input logic [9:0] w, input bit good);
    send_bit(1'b1);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
    send_bit(good ? 1'b0 : 1'b1);
    m_zrun = 0;
    if (!good) exp_err2++;
    else if (m_sync || m_active) begin
      if (m_sync) begin m_sync = 0; m_active = 1; m_idx = 0; end
      exp_q.push_back(w);
      if (m_idx % COLS == 0) exp_h++;
      m_idx++;
      if (m_idx == COLS * ROWS) begin m_active = 0; exp_vfall++; exp_brk[1] = 1'b1; end
    end
  endtask

  function automatic logic exp_hs();
    return m_active && (m_idx % COLS != 0);
  endfunction

  initial begin
    logic [31:0] got;
    logic [15:0] txw;
    int r0;
    #20;
    check("rst_par_raw", PAR_RAW, 0);
    check("rst_syncs", {PCLK, H_SYNC, V_SYNC, ERROR_OUT, ERROR_OUT2}, 0);
    check("rst_break_n", BREAK_N, 2'b11);
    check("rst_tx_oe_n", TX_OE_N, 1);
    check("cfg_fields", {ROWS_DELAY, MCLK_MODE, IDLE_MODE, MCLK_SPEED}, 9'h1A5);
    #20 RESET = 1'b1;
    #250;
    check("idle_break_n", BREAK_N, 2'b10);
    check("idle_pclk", pclk_rises, 0);
    check("idle_vsync", V_SYNC, 0);
    check("idle_par_raw", PAR_RAW, 0);

    // Lock on a preamble, sync, then two fixed words.
    send_bit(1'b1);
    send_zeros(20);
    send_word(10'h3FF, 1);
    send_word(10'h155, 1);
    send_zeros(4);
    check("first_vsync", V_SYNC, m_active);
    check("first_hsync", H_SYNC, exp_hs());
    check("first_pclk", pclk_rises, 2);
    check("first_par_raw", PAR_RAW, 10'h155);
    check("first_break_n", BREAK_N, 2'b11);

    // Complete the frame with random pixels.
    for (int i = 0; i < 6; i++) begin send_word(10'($urandom_range(0, 1023)), 1); send_zeros(4); end
    check("frame_vsync", V_SYNC, 0);
    check("frame_hsync", H_SYNC, 0);
    check("frame_pclk", pclk_rises, exp_q.size());
    check("frame_h_rises", h_rises, exp_h);
    check("frame_v_falls", v_falls, exp_vfall);
    check("frame_break_n", BREAK_N, exp_brk);

    // Bad stop bit, then a good word starts the frame.
    send_zeros(20);
    send_word(10'($urandom_range(0, 1023)), 0);
    send_zeros(4);
    check("badstop_err2", err2_cnt, exp_err2);
    check("badstop_pclk", pclk_rises, exp_q.size());
    send_word(10'($urandom_range(0, 1023)), 1);
    send_zeros(4);
    check("after_bad_vsync", V_SYNC, m_active);

    // Sync arriving after three words aborts the frame.
    send_word(10'($urandom_range(0, 1023)), 1);
    send_word(10'($urandom_range(0, 1023)), 1);
    send_zeros(20);
    check("abort_vsync", V_SYNC, 0);
    check("abort_hsync", H_SYNC, 0);
    check("abort_break_n", BREAK_N, exp_brk);

    // A full frame restores the frame-complete flag.
    for (int i = 0; i < 8; i++) send_word(10'($urandom_range(0, 1023)), 1);
    send_zeros(4);
    check("restore_break_n", BREAK_N, exp_brk);
    check("restore_v_falls", v_falls, exp_vfall);
    check("all_h_rises", h_rises, exp_h);
    check("pixel_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (i < cap_q.size()) got = 32'(cap_q[i]);
      check($sformatf("pixel%0d", i), got, 32'(exp_q[i]));
    end
    check("pclk_width", width_bad, 0);
    check("pclk_in_syncs", hv_bad, 0);
    check("no_code_err", err_cnt, 0);

    // Over-long interval while locked is a code error.
    #30 RX_DATA = 1'b1;
    #20;
    check("code_err", err_cnt, 1);
    #250;
    check("final_break_n", BREAK_N, 2'b10);

`ifdef CFG_TX_EN
    r0 = 0;
    if (oe_runs.size() > 0) r0 = oe_runs[0];
    txw = '0;
    for (int i = 0; i < 16; i++) if (i < tx_bits_q.size()) txw = {txw[14:0], tx_bits_q[i]};
    check("tx_oe_low_cycles", r0, 128);
    check("tx_word", txw, 16'hD280);
`else
    r0 = 0; txw = '0;
    check("tx_idle", tx_bad, 0);
    check("tx_no_bursts", oe_runs.size() + r0 + int'(txw), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
